// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the button debounce blocks.
//   - deb_state_e    : 2-bit FSM state encoding for the debouncer
//   - *_50MHZ        : default timing constants for a 50 MHz system clock
//   - *_SIM          : short timing constants for fast simulation
//   - idle_pin_level : raw pin level of a released button for a given polarity
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED      = 2'd0,
        ST_CHECK_PRESS   = 2'd1,
        ST_PRESSED       = 2'd2,
        ST_CHECK_RELEASE = 2'd3
    } deb_state_e;

    // 20 ms and 1 s at 50 MHz
    localparam int DEBOUNCE_CYC_50MHZ = 1000000;
    localparam int LONG_CYC_50MHZ     = 50000000;

    // Short values that keep simulation runs small
    localparam int DEBOUNCE_CYC_SIM   = 4;
    localparam int LONG_CYC_SIM       = 10;

    // Pin level seen when the button is not pressed
    function automatic logic idle_pin_level(input int active_low);
        if (active_low != 0) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input bit.
//   clk : destination clock
//   rst : asynchronous, active-high reset; both flops load RST_VAL
//   d   : asynchronous input
//   q   : synchronised output (two clk edges of latency)
// RST_VAL should be the idle level of the input so that leaving reset does not
// look like an input transition.
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Synchronises a raw mechanical button, rejects contact bounce and produces a
// clean level plus one-cycle press / release / long-press strobes.
//   clk           : system clock
//   rst           : asynchronous, active-high reset
//   button_in     : raw button pin, asynchronous, may bounce
//   btn_level     : debounced level, 1 = pressed (independent of ACTIVE_LOW)
//   press_pulse   : one-cycle strobe, coincides with first cycle btn_level = 1
//   release_pulse : one-cycle strobe when a release is accepted
//   long_pulse    : one-cycle strobe once per press when the hold hits LONG_CYC
// A level change is accepted after DEBOUNCE_CYC consecutive agreeing samples,
// i.e. DEBOUNCE_CYC+2 edges after the pin change is first sampled.
// -----------------------------------------------------------------------------
module button_debounce
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_50MHZ,
    parameter int LONG_CYC     = LONG_CYC_50MHZ,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic button_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int                DEB_W     = $clog2(DEBOUNCE_CYC);
    localparam int                HOLD_W    = $clog2(LONG_CYC);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic              IDLE_PIN  = idle_pin_level(ACTIVE_LOW);

    logic              pin_sync_s;
    logic              btn_s;

    deb_state_e        state_r;
    deb_state_e        state_nxt_s;
    logic [DEB_W-1:0]  deb_cnt_r;
    logic [DEB_W-1:0]  deb_cnt_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_nxt_s;
    logic              long_done_r;
    logic              long_done_nxt_s;

    logic              btn_level_r;
    logic              press_r;
    logic              release_r;
    logic              long_r;
    logic              level_nxt_s;
    logic              press_nxt_s;
    logic              release_nxt_s;
    logic              long_nxt_s;
    logic              in_hold_s;

    sync_2ff #(
        .RST_VAL (IDLE_PIN)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (button_in),
        .q   (pin_sync_s)
    );

    // Normalise polarity: btn_s = 1 means pressed
    assign btn_s = pin_sync_s ^ IDLE_PIN;

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RELEASED;
            deb_cnt_r   <= '0;
            hold_cnt_r  <= '0;
            long_done_r <= 1'b0;
            btn_level_r <= 1'b0;
            press_r     <= 1'b0;
            release_r   <= 1'b0;
            long_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            deb_cnt_r   <= deb_cnt_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            long_done_r <= long_done_nxt_s;
            btn_level_r <= level_nxt_s;
            press_r     <= press_nxt_s;
            release_r   <= release_nxt_s;
            long_r      <= long_nxt_s;
        end
    end

    // Next-state and debounce counter
    always_comb begin
        state_nxt_s   = state_r;
        deb_cnt_nxt_s = deb_cnt_r;
        case (state_r)
            ST_RELEASED: begin
                if (btn_s) begin
                    state_nxt_s   = ST_CHECK_PRESS;
                    deb_cnt_nxt_s = DEB_W'(1);
                end else begin
                    deb_cnt_nxt_s = '0;
                end
            end
            ST_CHECK_PRESS: begin
                if (!btn_s) begin
                    state_nxt_s   = ST_RELEASED;
                    deb_cnt_nxt_s = '0;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_nxt_s   = ST_PRESSED;
                    deb_cnt_nxt_s = '0;
                end else begin
                    deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!btn_s) begin
                    state_nxt_s   = ST_CHECK_RELEASE;
                    deb_cnt_nxt_s = DEB_W'(1);
                end else begin
                    deb_cnt_nxt_s = '0;
                end
            end
            ST_CHECK_RELEASE: begin
                if (btn_s) begin
                    // Glitch while held: back to PRESSED, hold time keeps running
                    state_nxt_s   = ST_PRESSED;
                    deb_cnt_nxt_s = '0;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_nxt_s   = ST_RELEASED;
                    deb_cnt_nxt_s = '0;
                end else begin
                    deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
                end
            end
            default: begin
                state_nxt_s   = ST_RELEASED;
                deb_cnt_nxt_s = '0;
            end
        endcase
    end

    // Output strobes, debounced level and hold timer
    always_comb begin
        press_nxt_s     = (state_r == ST_CHECK_PRESS)   && (state_nxt_s == ST_PRESSED);
        release_nxt_s   = (state_r == ST_CHECK_RELEASE) && (state_nxt_s == ST_RELEASED);
        level_nxt_s     = (state_nxt_s == ST_PRESSED) || (state_nxt_s == ST_CHECK_RELEASE);
        in_hold_s       = (state_r == ST_PRESSED) || (state_r == ST_CHECK_RELEASE);
        // Fires once per press; suppressed on the cycle a release is accepted
        long_nxt_s      = in_hold_s && !release_nxt_s && !long_done_r &&
                          (hold_cnt_r == HOLD_LAST);
        hold_cnt_nxt_s  = hold_cnt_r;
        long_done_nxt_s = long_done_r;

        if (press_nxt_s) begin
            hold_cnt_nxt_s = '0;
        end else if (in_hold_s && (hold_cnt_r != HOLD_LAST)) begin
            hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
        end else begin
            hold_cnt_nxt_s = hold_cnt_r;
        end

        if (press_nxt_s) begin
            long_done_nxt_s = 1'b0;
        end else if (long_nxt_s) begin
            long_done_nxt_s = 1'b1;
        end else begin
            long_done_nxt_s = long_done_r;
        end
    end

    assign btn_level     = btn_level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign long_pulse    = long_r;

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
// Directed and randomised stimulus for button_debounce (DEBOUNCE_CYC=4,
// LONG_CYC=10, ACTIVE_LOW=1). The reference model keeps the history of
// sampled pin values and decides each cycle whether the last DEBOUNCE_CYC
// synchronised samples all disagree with the current level.
// -----------------------------------------------------------------------------
module tb_button_debounce;

    localparam int D = 4;
    localparam int L = 10;

    logic clk;
    logic rst;
    logic button_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit hist[$];
    int edge_n;
    bit m_level, m_press, m_release, m_long;
    int m_press_edge;
    int m_press_total = 0, m_release_total = 0, m_long_total = 0;

    // Observed DUT activity
    int d_press_total = 0, d_release_total = 0, d_long_total = 0;
    int last_press_edge = -1, last_release_edge = -1, last_long_edge = -1;

    button_debounce #(
        .DEBOUNCE_CYC (D),
        .LONG_CYC     (L),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .button_in     (button_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit observed(input int idx);
        if (idx < 0) return 1'b0;
        return hist[idx];
    endfunction

    task automatic model_reset();
        hist.delete();
        edge_n       = -1;
        m_level      = 1'b0;
        m_press      = 1'b0;
        m_release    = 1'b0;
        m_long       = 1'b0;
        m_press_edge = -100000;
    endtask

    // One clock edge of the reference model; pin is the raw value sampled
    task automatic model_edge(input logic pin);
        bit all_diff;
        hist.push_back(pin == 1'b0);
        edge_n   = hist.size() - 1;
        all_diff = 1'b1;
        // The FSM sees the pin two edges late
        for (int j = 0; j < D; j++) begin
            if (observed(edge_n - 2 - j) == m_level) all_diff = 1'b0;
        end
        m_press   = !m_level && all_diff;
        m_release = m_level && all_diff;
        m_long    = m_level && !all_diff && ((edge_n - m_press_edge) == L);
        if (m_press) begin
            m_level      = 1'b1;
            m_press_edge = edge_n;
        end else if (m_release) begin
            m_level = 1'b0;
        end
        if (m_press)   m_press_total++;
        if (m_release) m_release_total++;
        if (m_long)    m_long_total++;
    endtask

    task automatic check_outputs();
        chk("btn_level", btn_level, m_level);
        chk("press_pulse", press_pulse, m_press);
        chk("release_pulse", release_pulse, m_release);
        chk("long_pulse", long_pulse, m_long);
        if (press_pulse === 1'b1) begin
            d_press_total++;
            last_press_edge = edge_n;
        end
        if (release_pulse === 1'b1) begin
            d_release_total++;
            last_release_edge = edge_n;
        end
        if (long_pulse === 1'b1) begin
            d_long_total++;
            last_long_edge = edge_n;
        end
    endtask

    // Starts and ends on a falling edge
    task automatic tick(input logic pin);
        button_in = pin;
        @(posedge clk);
        model_edge(pin);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic hold_pin(input logic pin, input int n);
        for (int i = 0; i < n; i++) tick(pin);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_level"}, btn_level, 1'b0);
        chk({tag, "_press"}, press_pulse, 1'b0);
        chk({tag, "_release"}, release_pulse, 1'b0);
        chk({tag, "_long"}, long_pulse, 1'b0);
    endtask

    // Starts and ends on a falling edge
    task automatic apply_reset(input logic pin, input int n);
        rst       = 1'b1;
        button_in = pin;
        #1;
        check_all_zero("rst_async");
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_all_zero("rst_hold");
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int   s;
        int   p0, r0, l0, pe;
        logic tgt, p;
        int   len;

        rst       = 1'b1;
        button_in = 1'b1;
        model_reset();
        @(negedge clk);
        apply_reset(1'b1, 3);

        // Idle after reset
        hold_pin(1'b1, 20);
        chk_int("idle_quiet", d_press_total + d_release_total + d_long_total, 0);

        // Clean press, then held for 30 cycles in total
        s  = edge_n + 1;
        p0 = d_press_total;
        l0 = d_long_total;
        hold_pin(1'b0, 8);
        chk_int("press_latency", last_press_edge, s + D + 1);
        chk_int("press_once", d_press_total - p0, 1);
        hold_pin(1'b0, 22);
        chk_int("long_once", d_long_total - l0, 1);
        chk_int("long_latency", last_long_edge, last_press_edge + L);

        // Clean release
        s  = edge_n + 1;
        r0 = d_release_total;
        hold_pin(1'b1, 8);
        chk_int("release_latency", last_release_edge, s + D + 1);
        chk_int("release_once", d_release_total - r0, 1);

        // Bounce on press: 0,0,1,0,0,0,0 then held low
        s  = edge_n + 1;
        p0 = d_press_total;
        tick(1'b0); tick(1'b0); tick(1'b1);
        hold_pin(1'b0, 8);
        chk_int("bounce_press_latency", last_press_edge, s + D + 4);
        chk_int("bounce_press_once", d_press_total - p0, 1);
        hold_pin(1'b1, 8);

        // Release glitch while pressed
        s  = edge_n + 1;
        r0 = d_release_total;
        l0 = d_long_total;
        hold_pin(1'b0, 10);
        pe = last_press_edge;
        chk_int("glitch_press_latency", pe, s + D + 1);
        hold_pin(1'b1, 2);
        hold_pin(1'b0, 16);
        chk_int("glitch_no_release", d_release_total - r0, 0);
        chk_int("glitch_long_latency", last_long_edge, pe + L);
        chk_int("glitch_long_once", d_long_total - l0, 1);
        hold_pin(1'b1, 8);

        // Reset while in the press check, button still low afterwards
        r0 = d_release_total;
        hold_pin(1'b0, 3);
        apply_reset(1'b0, 2);
        s = edge_n + 1;
        hold_pin(1'b0, 8);
        chk_int("rst_mid_press_latency", last_press_edge, s + D + 1);
        chk_int("rst_mid_no_release", d_release_total - r0, 0);
        hold_pin(1'b1, 8);

        // Randomised bouncy segments with one reset in the middle
        for (int seg = 0; seg < 40; seg++) begin
            tgt = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
            len = $urandom_range(1, 14);
            for (int c = 0; c < len; c++) begin
                p = tgt;
                if ($urandom_range(0, 5) == 0) p = ~tgt;
                tick(p);
            end
            if (seg == 25) apply_reset(tgt, 1);
        end
        hold_pin(1'b1, 8);

        chk_int("total_press", d_press_total, m_press_total);
        chk_int("total_release", d_release_total, m_release_total);
        chk_int("total_long", d_long_total, m_long_total);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
